// File: rtl/dram4416_ctrl.sv
// dram4416_ctrl: RAS/CAS initiator for one TMS4416 16k x 4 DRAM bank with optional RAS-only refresh.
//   Optional refresh feature: define DRAM4416_CTRL_REFRESH_EN.
//   clk, clr_n       clock (posedge) and asynchronous active-low reset
//   req, we          access request (level) and direction (1=write)
//   addr, wdata      word address ([13:6] row, [5:0] column) and write data
//   rdata, ack, busy read data (held), one-cycle completion pulse, controller not idle
//   rasn, casn       registered DRAM strobes
//   gn, wn           registered DRAM output / write enables
//   a, din, dout     multiplexed DRAM address, data to DRAM, data from DRAM
module dram4416_ctrl #(
   parameter int PRECHARGE_CYCLES = 1,
   parameter int REFRESH_INTERVAL = 256,
   parameter int RFSH_RAS_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        req,
   input  logic        we,
   input  logic [13:0] addr,
   input  logic [3:0]  wdata,
   output logic [3:0]  rdata,
   output logic        ack,
   output logic        busy,
   output logic        rasn,
   output logic        casn,
   output logic        gn,
   output logic        wn,
   output logic [7:0]  a,
   output logic [3:0]  din,
   input  logic [3:0]  dout
);
   typedef enum logic [3:0] {IDLE, ADDR, RAS, COL, CAS, DATA, PRE, RADDR, RRAS} state_t;
   state_t state, state_n;
   logic we_q, we_n;
   logic [5:0] col_q, col_n;
   logic [15:0] pcnt, pcnt_n;
   logic rasn_n, casn_n, gn_n, wn_n, ack_n;
   logic [7:0] a_n;
   logic [3:0] din_n, rdata_n;
   logic rfsh_go;
   logic [7:0] rfsh_row;
   assign busy = state != IDLE;
`ifdef DRAM4416_CTRL_REFRESH_EN
   logic [15:0] timer, rcnt, rcnt_n;
   logic pending, rfsh_done, expire;
   assign expire  = timer == 16'(REFRESH_INTERVAL - 1);
   assign rfsh_go = pending;
   // An expiry on the same edge the refresh finishes re-arms pending rather than being lost.
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         timer    <= '0;
         pending  <= 1'b0;
         rfsh_row <= '0;
         rcnt     <= '0;
      end else begin
         timer    <= expire ? '0 : timer + 16'd1;
         pending  <= (pending & ~rfsh_done) | expire;
         rfsh_row <= rfsh_row + {7'd0, rfsh_done};
         rcnt     <= rcnt_n;
      end
`else
   logic unused_cfg;
   assign rfsh_go    = 1'b0;
   assign rfsh_row   = '0;
   assign unused_cfg = ^{REFRESH_INTERVAL, RFSH_RAS_CYCLES};
`endif
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         state <= IDLE;
         rasn  <= 1'b1;
         casn  <= 1'b1;
         gn    <= 1'b1;
         wn    <= 1'b1;
         a     <= '0;
         din   <= '0;
         rdata <= '0;
         ack   <= 1'b0;
         we_q  <= 1'b0;
         col_q <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_n;
         rasn  <= rasn_n;
         casn  <= casn_n;
         gn    <= gn_n;
         wn    <= wn_n;
         a     <= a_n;
         din   <= din_n;
         rdata <= rdata_n;
         ack   <= ack_n;
         we_q  <= we_n;
         col_q <= col_n;
         pcnt  <= pcnt_n;
      end
   // Strobes and a are never updated on the same edge, so the DRAM's negedge latches see stable a.
   always_comb begin
      state_n = state;
      rasn_n  = rasn;
      casn_n  = casn;
      gn_n    = gn;
      wn_n    = wn;
      a_n     = a;
      din_n   = din;
      rdata_n = rdata;
      ack_n   = 1'b0;
      we_n    = we_q;
      col_n   = col_q;
      pcnt_n  = pcnt;
`ifdef DRAM4416_CTRL_REFRESH_EN
      rcnt_n    = rcnt;
      rfsh_done = 1'b0;
`endif
      case (state)
         IDLE:
            if (rfsh_go) begin
               state_n = RADDR;
               a_n     = rfsh_row;
            end else if (req) begin
               state_n = ADDR;
               a_n     = addr[13:6];
               din_n   = wdata;
               we_n    = we;
               col_n   = addr[5:0];
            end
         ADDR: begin
            state_n = RAS;
            rasn_n  = 1'b0;
         end
         RAS: begin
            state_n = COL;
            a_n     = {1'b0, col_q, 1'b0};
         end
         COL: begin
            state_n = CAS;
            casn_n  = 1'b0;
            wn_n    = ~we_q;
            gn_n    = we_q;
         end
         CAS: state_n = DATA;
         DATA: begin
            state_n = PRE;
            rasn_n  = 1'b1;
            casn_n  = 1'b1;
            gn_n    = 1'b1;
            wn_n    = 1'b1;
            ack_n   = 1'b1;
            rdata_n = we_q ? rdata : dout;
            pcnt_n  = '0;
         end
         PRE:
            if (pcnt == 16'(PRECHARGE_CYCLES - 1)) state_n = IDLE;
            else pcnt_n = pcnt + 16'd1;
`ifdef DRAM4416_CTRL_REFRESH_EN
         RADDR: begin
            state_n = RRAS;
            rasn_n  = 1'b0;
            rcnt_n  = '0;
         end
         RRAS:
            if (rcnt == 16'(RFSH_RAS_CYCLES - 1)) begin
               state_n   = PRE;
               rasn_n    = 1'b1;
               pcnt_n    = '0;
               rfsh_done = 1'b1;
            end else rcnt_n = rcnt + 16'd1;
`endif
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_dram4416_ctrl.sv
// tb_dram4416_ctrl: scoreboard bench for dram4416_ctrl with a behavioural TMS4416 model.
module tb_dram4416_ctrl;
   logic clk = 1'b0, clr_n = 1'b1, req = 1'b0, we = 1'b0;
   logic [13:0] addr = '0;
   logic [3:0] wdata = '0, dout, rdata, din;
   logic ack, busy, rasn, casn, gn, wn;
   logic [7:0] a;
   int checks = 0, errors = 0;
   typedef struct {logic w; logic [13:0] ad; logic [3:0] d;} exp_t;
   exp_t sb[$];
   logic [3:0] ref_mem [0:16383];
   logic [3:0] mem [0:16383];
   logic [7:0] lrow;
   logic [5:0] lcol;
   logic p_rasn = 1'b1, p_casn = 1'b1, cas_seen = 1'b1, cas_wn, cas_gn;
   logic [7:0] ras_a, cas_a;
   int low;
   logic [7:0] rf_row[$];
   int rf_low[$];

   always #5 clk = ~clk;

   dram4416_ctrl #(.PRECHARGE_CYCLES(1), .REFRESH_INTERVAL(16), .RFSH_RAS_CYCLES(2)) dut (
      .clk(clk), .clr_n(clr_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .busy(busy), .rasn(rasn), .casn(casn), .gn(gn), .wn(wn),
      .a(a), .din(din), .dout(dout));

   always @(negedge rasn) lrow <= a;
   always @(negedge casn) lcol <= a[6:1];
   always @(posedge clk)
      if (!rasn && !casn) begin
         if (!gn) dout <= mem[{lrow, lcol}];
         if (!wn) mem[{lrow, lcol}] <= din;
      end

   // Strobe monitor: a rasn-low period without any casn fall is logged as a refresh.
   initial forever begin
      @(negedge clk);
      if (p_rasn && !rasn) begin ras_a = a; low = 0; cas_seen = 1'b0; end
      if (!rasn) low++;
      if (p_casn && !casn) begin cas_a = a; cas_wn = wn; cas_gn = gn; cas_seen = 1'b1; end
      if (!p_rasn && rasn && !cas_seen) begin rf_row.push_back(ras_a); rf_low.push_back(low); end
      p_rasn = rasn;
      p_casn = casn;
   end

   task automatic pulse();
      @(negedge clk);
      clr_n = 1'b0;
      req = 1'b0;
      @(negedge clk);
      clr_n = 1'b1;
   endtask

   task automatic do_access(input logic w, input logic [13:0] ad, input logic [3:0] wd,
                            output int lat, output logic [3:0] rd);
      int n = 0;
      req = 1'b1; we = w; addr = ad; wdata = wd;
      do begin @(negedge clk); n++; end while (!ack && n < 40);
      lat = ack ? n - 1 : -1;
      rd = rdata;
      req = 1'b0;
   endtask

   task automatic test_reset();
      #2 clr_n = 1'b0;
      #1;
      checks++;
      if ({rasn, casn, gn, wn, a, din, rdata, ack, busy} !== {4'hF, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state got %b exp %b", {rasn, casn, gn, wn, a, din, rdata, ack, busy},
                  {4'hF, 8'h00, 4'h0, 4'h0, 1'b0, 1'b0});
      end
      @(negedge clk) clr_n = 1'b1;
   endtask

   task automatic test_write();
      int lat; logic [3:0] rd; exp_t e;
      pulse();
      ref_mem[14'h1234] = 4'hA;
      sb.push_back('{1'b1, 14'h1234, 4'hA});
      do_access(1'b1, 14'h1234, 4'hA, lat, rd);
      e = sb.pop_front();
      checks++; if (lat !== 5) begin errors++; $display("FAIL wr_latency got %0d exp 5", lat); end
      checks++; if (ras_a !== e.ad[13:6]) begin errors++; $display("FAIL wr_row got %h exp %h", ras_a, e.ad[13:6]); end
      checks++; if (cas_a !== {1'b0, e.ad[5:0], 1'b0}) begin errors++; $display("FAIL wr_col got %h exp %h", cas_a, {1'b0, e.ad[5:0], 1'b0}); end
      checks++; if ({cas_wn, cas_gn} !== 2'b01) begin errors++; $display("FAIL wr_enables got wn,gn=%b exp 01", {cas_wn, cas_gn}); end
   endtask

   task automatic test_read();
      int lat; logic [3:0] rd; exp_t e;
      pulse();
      sb.push_back('{1'b0, 14'h1234, ref_mem[14'h1234]});
      do_access(1'b0, 14'h1234, 4'h0, lat, rd);
      e = sb.pop_front();
      checks++; if (lat !== 5) begin errors++; $display("FAIL rd_latency got %0d exp 5", lat); end
      checks++; if ({cas_wn, cas_gn} !== 2'b10) begin errors++; $display("FAIL rd_enables got wn,gn=%b exp 10", {cas_wn, cas_gn}); end
      checks++; if (rd !== e.d) begin errors++; $display("FAIL rd_data got %h exp %h", rd, e.d); end
      repeat (3) @(negedge clk);
      checks++; if (rdata !== e.d) begin errors++; $display("FAIL rd_hold got %h exp %h", rdata, e.d); end
      ref_mem[14'h0555] = 4'h5;
      do_access(1'b1, 14'h0555, 4'h5, lat, rd);
      repeat (2) @(negedge clk);
      checks++; if (rdata !== e.d) begin errors++; $display("FAIL rd_hold_write got %h exp %h", rdata, e.d); end
   endtask

   task automatic test_back_to_back();
      time t[4]; int n, lat, per, exp_per; logic [3:0] rd; exp_t e;
      pulse();
      req = 1'b1; we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         addr = 14'(i); wdata = 4'(9 + i);
         ref_mem[i] = wdata;
         sb.push_back('{1'b1, addr, wdata});
         n = 0;
         do begin @(negedge clk); n++; end while (!ack && n < 40);
         t[i] = $time;
         e = sb.pop_front();
         checks++; if (ack !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d got %b exp 1", i, ack); end
         checks++; if ({ras_a, cas_a} !== {e.ad[13:6], 1'b0, e.ad[5:0], 1'b0}) begin
            errors++; $display("FAIL b2b_addr%0d got %h exp %h", i, {ras_a, cas_a}, {e.ad[13:6], 1'b0, e.ad[5:0], 1'b0});
         end
      end
      req = 1'b0;
      for (int i = 1; i < 4; i++) begin
         per = int'((t[i] - t[i-1]) / 10);
`ifdef DRAM4416_CTRL_REFRESH_EN
         exp_per = (i == 3) ? 12 : 7;
`else
         exp_per = 7;
`endif
         checks++; if (per !== exp_per) begin errors++; $display("FAIL b2b_period%0d got %0d exp %0d", i, per, exp_per); end
      end
      for (int i = 0; i < 4; i++) sb.push_back('{1'b0, 14'(i), ref_mem[i]});
      for (int i = 0; i < 4; i++) begin
         do_access(1'b0, 14'(i), 4'h0, lat, rd);
         e = sb.pop_front();
         checks++; if (rd !== e.d) begin errors++; $display("FAIL b2b_readback%0d got %h exp %h", i, rd, e.d); end
      end
   endtask

`ifdef DRAM4416_CTRL_REFRESH_EN
   task automatic test_refresh_priority();
      int lat; logic [3:0] rd; exp_t e;
      pulse();
      repeat (16) @(posedge clk);
      @(negedge clk);
      rf_row.delete(); rf_low.delete();
      sb.push_back('{1'b0, 14'h1234, ref_mem[14'h1234]});
      do_access(1'b0, 14'h1234, 4'h0, lat, rd);
      e = sb.pop_front();
      checks++; if (lat !== 10) begin errors++; $display("FAIL rf_prio_latency got %0d exp 10", lat); end
      checks++; if (rd !== e.d) begin errors++; $display("FAIL rf_prio_data got %h exp %h", rd, e.d); end
      checks++; if (rf_row.size() !== 1) begin errors++; $display("FAIL rf_prio_count got %0d exp 1", rf_row.size()); end
      else begin
         checks++; if ({rf_row[0], 8'(rf_low[0])} !== {8'h00, 8'd2}) begin
            errors++; $display("FAIL rf_prio_row got row %h low %0d exp row 00 low 2", rf_row[0], rf_low[0]);
         end
      end
   endtask

   task automatic test_refresh_rows();
      int n = 0;
      pulse();
      @(negedge clk);
      rf_row.delete(); rf_low.delete();
      while (rf_row.size() < 257 && n < 257 * 16 + 200) begin @(negedge clk); n++; end
      checks++; if (rf_row.size() < 257) begin errors++; $display("FAIL rf_rows_count got %0d exp 257", rf_row.size()); end
      for (int i = 0; i < rf_row.size() && i < 257; i++) begin
         checks++; if ({rf_row[i], 8'(rf_low[i])} !== {8'(i), 8'd2}) begin
            errors++; $display("FAIL rf_row%0d got row %h low %0d exp row %h low 2", i, rf_row[i], rf_low[i], 8'(i));
         end
      end
   endtask
`endif

   task automatic test_reset_mid_access();
      int n = 0, acks = 0, lat; logic [3:0] rd; exp_t e;
      pulse();
      req = 1'b1; we = 1'b1; addr = 14'h2222; wdata = 4'h7;
      do begin @(negedge clk); n++; end while (casn && n < 20);
      clr_n = 1'b0;
      #1;
      checks++; if ({rasn, casn, gn, wn, busy, ack} !== 6'b111100) begin
         errors++; $display("FAIL abort_strobes got %b exp 111100", {rasn, casn, gn, wn, busy, ack});
      end
      req = 1'b0;
      @(negedge clk) clr_n = 1'b1;
      repeat (8) begin @(negedge clk); if (ack) acks++; end
      checks++; if (acks !== 0) begin errors++; $display("FAIL abort_ack got %0d exp 0", acks); end
      sb.push_back('{1'b0, 14'h1234, ref_mem[14'h1234]});
      do_access(1'b0, 14'h1234, 4'h0, lat, rd);
      e = sb.pop_front();
      checks++; if ({lat, rd} !== {32'd5, e.d}) begin errors++; $display("FAIL abort_read got lat %0d data %h exp lat 5 data %h", lat, rd, e.d); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
`ifdef DRAM4416_CTRL_REFRESH_EN
      test_refresh_priority();
      test_refresh_rows();
`endif
      test_reset_mid_access();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
